// File: rtl/apb_reg_bank.sv
// APB3 slave register bank in front of the ECC datapath: configuration registers,
// a start pulse on CTRL writes, busy tracking and captured status for readback.
module apb_reg_bank #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [AMBA_WORD-1:0]       PWDATA,
    output logic [AMBA_WORD-1:0]       PRDATA,
    output logic                       PREADY,
    output logic                       PSLVERR,
    input  logic                       operation_done,
    input  logic [DATA_WIDTH-1:0]      data_out_in,
    input  logic [1:0]                 num_of_errors_in,
    output logic                       start,
    output logic [AMBA_WORD-1:0]       CTRL,
    output logic [AMBA_WORD-1:0]       DATA_IN,
    output logic [AMBA_WORD-1:0]       CODEWORD_WIDTH,
    output logic [AMBA_WORD-1:0]       NOISE,
    output logic                       busy
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    localparam logic [2:0] SEL_CTRL  = 3'd0;
    localparam logic [2:0] SEL_DIN   = 3'd1;
    localparam logic [2:0] SEL_CW    = 3'd2;
    localparam logic [2:0] SEL_NOISE = 3'd3;
    localparam logic [2:0] SEL_DOUT  = 3'd4;
    localparam logic [2:0] SEL_STAT  = 3'd5;

    apb_state_e           state_q, state_d;
    logic [1:0]           ctrl_q, ctrl_d;
    logic [AMBA_WORD-1:0] dataIn_q, dataIn_d;
    logic [1:0]           cw_q, cw_d;
    logic [AMBA_WORD-1:0] noise_q, noise_d;
    logic [AMBA_WORD-1:0] dout_q, dout_d;
    logic [1:0]           nerr_q, nerr_d;
    logic                 busy_q, busy_d;
    logic                 start_q, start_d;
    logic [AMBA_WORD-1:0] prdata_q, prdata_d;
    logic                 pslverr_q, pslverr_d;

    logic [2:0]           regSel;
    logic                 setupEntry;
    logic                 accessErr;
    logic                 wrCommit;
    logic                 startFire;
    logic                 opDone;
    logic [AMBA_WORD-1:0] readData;
    logic                 unusedAddrBits;

    assign regSel         = PADDR[4:2];
    assign unusedAddrBits = ^{PADDR[AMBA_ADDR_WIDTH-1:5], PADDR[1:0]};

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) state_d = SETUP;
            end
            SETUP: begin
                if (PSEL && PENABLE) state_d = ACCESS;
                else if (PSEL)       state_d = SETUP;
                else                 state_d = IDLE;
            end
            ACCESS: begin
                if (PSEL && !PENABLE) state_d = SETUP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        readData = '0;
        case (regSel)
            SEL_CTRL:  readData = AMBA_WORD'(ctrl_q);
            SEL_DIN:   readData = dataIn_q;
            SEL_CW:    readData = AMBA_WORD'(cw_q);
            SEL_NOISE: readData = noise_q;
            SEL_DOUT:  readData = dout_q;
            SEL_STAT:  readData = AMBA_WORD'({busy_q, nerr_q});
            default:   readData = '0;
        endcase
    end

    // The error decision is taken at setup entry and reused to gate the commit one cycle later.
    always_comb begin
        setupEntry = PSEL && !PENABLE;
        accessErr  = (regSel[2] && regSel[1]) ||
                     (PWRITE && (regSel == SEL_DOUT || regSel == SEL_STAT || busy_q));
        wrCommit   = (state_q == SETUP) && PSEL && PENABLE && PWRITE && !pslverr_q;
        startFire  = wrCommit && (regSel == SEL_CTRL) && !busy_q;
        opDone     = operation_done && busy_q && !start_q;
    end

    always_comb begin
        ctrl_d    = ctrl_q;
        dataIn_d  = dataIn_q;
        cw_d      = cw_q;
        noise_d   = noise_q;
        dout_d    = dout_q;
        nerr_d    = nerr_q;
        busy_d    = busy_q;
        start_d   = startFire;
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;

        if (wrCommit) begin
            case (regSel)
                SEL_CTRL:  ctrl_d   = PWDATA[1:0];
                SEL_DIN:   dataIn_d = PWDATA;
                SEL_CW:    cw_d     = PWDATA[1:0];
                SEL_NOISE: noise_d  = PWDATA;
                default:   ;
            endcase
        end

        if (startFire) begin
            busy_d = 1'b1;
        end else if (opDone) begin
            busy_d = 1'b0;
            dout_d = AMBA_WORD'(data_out_in);
            nerr_d = num_of_errors_in;
        end

        if (setupEntry && !PWRITE) prdata_d = readData;

        if (setupEntry)            pslverr_d = accessErr;
        else if (state_d == IDLE)  pslverr_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            ctrl_q    <= '0;
            dataIn_q  <= '0;
            cw_q      <= '0;
            noise_q   <= '0;
            dout_q    <= '0;
            nerr_q    <= '0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            dataIn_q  <= dataIn_d;
            cw_q      <= cw_d;
            noise_q   <= noise_d;
            dout_q    <= dout_d;
            nerr_q    <= nerr_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign PRDATA         = prdata_q;
    assign PREADY         = 1'b1;
    assign PSLVERR        = pslverr_q;
    assign start          = start_q;
    assign busy           = busy_q;
    assign CTRL           = AMBA_WORD'(ctrl_q);
    assign DATA_IN        = dataIn_q;
    assign CODEWORD_WIDTH = AMBA_WORD'(cw_q);
    assign NOISE          = noise_q;

endmodule

// File: tb/tb_apb_reg_bank.sv
// Self-checking bench for apb_reg_bank: directed register/protocol cases followed by
// randomized APB traffic scored against an array-based model of the register map.
module tb_apb_reg_bank;

    logic        clk;
    logic        rst;
    logic [19:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        operation_done;
    logic [31:0] data_out_in;
    logic [1:0]  num_of_errors_in;
    logic        start;
    logic [31:0] CTRL;
    logic [31:0] DATA_IN;
    logic [31:0] CODEWORD_WIDTH;
    logic [31:0] NOISE;
    logic        busy;

    int errorCount = 0;
    int checkCount = 0;

    // Reference model: four RW registers, captured result, error count and busy flag.
    logic [31:0] mReg [4];
    logic [31:0] mDout;
    logic [1:0]  mNerr;
    bit          mBusy;

    apb_reg_bank #(
        .AMBA_WORD(32),
        .AMBA_ADDR_WIDTH(20),
        .DATA_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .PADDR(PADDR),
        .PSEL(PSEL),
        .PENABLE(PENABLE),
        .PWRITE(PWRITE),
        .PWDATA(PWDATA),
        .PRDATA(PRDATA),
        .PREADY(PREADY),
        .PSLVERR(PSLVERR),
        .operation_done(operation_done),
        .data_out_in(data_out_in),
        .num_of_errors_in(num_of_errors_in),
        .start(start),
        .CTRL(CTRL),
        .DATA_IN(DATA_IN),
        .CODEWORD_WIDTH(CODEWORD_WIDTH),
        .NOISE(NOISE),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < 4; i++) mReg[i] = '0;
        mDout = '0;
        mNerr = '0;
        mBusy = 1'b0;
    endfunction

    function automatic logic [31:0] modelRead(input int idx);
        case (idx)
            0, 1, 2, 3: return mReg[idx];
            4:          return mDout;
            5:          return {29'd0, mBusy, mNerr};
            default:    return 32'd0;
        endcase
    endfunction

    function automatic bit modelErr(input int idx, input bit wr);
        return (idx >= 6) || (wr && (idx >= 4 || mBusy));
    endfunction

    function automatic logic [19:0] makeAddr(input int idx);
        logic [19:0] a;
        logic [2:0]  sel;
        a      = 20'($urandom);
        sel    = 3'(idx);
        a[4:2] = sel;
        return a;
    endfunction

    task automatic checkRegs(input string tag);
        checkOutput({tag, "_ctrl"},  CTRL,           mReg[0]);
        checkOutput({tag, "_din"},   DATA_IN,        mReg[1]);
        checkOutput({tag, "_cw"},    CODEWORD_WIDTH, mReg[2]);
        checkOutput({tag, "_noise"}, NOISE,          mReg[3]);
        checkOutput({tag, "_busy"},  32'(busy),      32'(mBusy));
    endtask

    task automatic applyStimulusWrite(input int idx, input logic [31:0] data, input bit doneInStart);
        bit expErr;
        bit expStart;
        expErr   = modelErr(idx, 1'b1);
        expStart = !expErr && (idx == 0) && !mBusy;
        @(negedge clk);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = makeAddr(idx);
        PWDATA  = data;
        @(negedge clk);
        PENABLE = 1'b1;
        checkOutput("wr_pslverr", 32'(PSLVERR), 32'(expErr));
        @(negedge clk);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        if (!expErr) begin
            if (idx == 0 || idx == 2) mReg[idx] = data & 32'h3;
            else                      mReg[idx] = data;
        end
        if (expStart) mBusy = 1'b1;
        checkOutput("start_pulse", 32'(start), 32'(expStart));
        if (doneInStart && expStart) begin
            operation_done   = 1'b1;
            data_out_in      = $urandom;
            num_of_errors_in = 2'($urandom);
        end
        @(negedge clk);
        operation_done = 1'b0;
        checkOutput("start_clear", 32'(start), 32'd0);
        checkOutput("wr_pslverr_idle", 32'(PSLVERR), 32'd0);
        checkRegs("after_wr");
    endtask

    task automatic applyStimulusRead(input int idx);
        logic [31:0] expData;
        bit          expErr;
        expData = modelRead(idx);
        expErr  = modelErr(idx, 1'b0);
        @(negedge clk);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = makeAddr(idx);
        PWDATA  = $urandom;
        @(negedge clk);
        PENABLE = 1'b1;
        checkOutput($sformatf("rd_data_%0d", idx), PRDATA, expData);
        checkOutput("rd_pslverr", 32'(PSLVERR), 32'(expErr));
        @(negedge clk);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        @(negedge clk);
        checkOutput("rd_pslverr_idle", 32'(PSLVERR), 32'd0);
    endtask

    task automatic applyStimulusDone(input logic [31:0] data, input logic [1:0] nerr);
        @(negedge clk);
        operation_done   = 1'b1;
        data_out_in      = data;
        num_of_errors_in = nerr;
        @(negedge clk);
        operation_done = 1'b0;
        if (mBusy) begin
            mDout = data;
            mNerr = nerr;
            mBusy = 1'b0;
        end
        checkOutput("done_busy", 32'(busy), 32'(mBusy));
    endtask

    task automatic applyStimulusReset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        modelReset();
        checkRegs("rst_mid");
        checkOutput("rst_mid_start", 32'(start), 32'd0);
    endtask

    task automatic applyStimulusViolation();
        @(negedge clk);
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = 1'b1;
        PADDR   = makeAddr(3);
        PWDATA  = ~mReg[3];
        @(negedge clk);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        @(negedge clk);
        checkOutput("viol_pslverr", 32'(PSLVERR), 32'd0);
        checkRegs("viol");
    endtask

    initial begin
        rst              = 1'b0;
        PSEL             = 1'b0;
        PENABLE          = 1'b0;
        PWRITE           = 1'b0;
        PADDR            = '0;
        PWDATA           = '0;
        operation_done   = 1'b0;
        data_out_in      = '0;
        num_of_errors_in = '0;
        modelReset();

        repeat (2) begin
            @(negedge clk);
            PSEL = ~PSEL;
        end
        checkRegs("reset");
        checkOutput("reset_start",   32'(start),   32'd0);
        checkOutput("reset_prdata",  PRDATA,       32'd0);
        checkOutput("reset_pslverr", 32'(PSLVERR), 32'd0);
        checkOutput("reset_pready",  32'(PREADY),  32'd1);
        PSEL = 1'b0;
        rst  = 1'b1;
        applyStimulusRead(5);

        applyStimulusWrite(1, 32'hA5A5_0F0F, 1'b0);
        applyStimulusWrite(2, 32'h0000_0002, 1'b0);
        applyStimulusWrite(3, 32'h0000_0010, 1'b0);
        applyStimulusWrite(0, 32'h0000_0001, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulusRead(i);
        applyStimulusRead(5);
        applyStimulusDone(32'h1234_5678, 2'b01);
        applyStimulusRead(4);
        applyStimulusRead(5);

        applyStimulusWrite(0, 32'h0000_0002, 1'b0);
        applyStimulusWrite(3, 32'hFFFF_FFFF, 1'b0);
        applyStimulusWrite(0, 32'h0000_0001, 1'b0);
        applyStimulusDone(32'hCAFE_0001, 2'b10);

        applyStimulusWrite(4, 32'hDEAD_BEEF, 1'b0);
        applyStimulusRead(6);
        applyStimulusWrite(0, 32'hFFFF_FFFF, 1'b0);
        applyStimulusRead(0);
        applyStimulusDone(32'h0BAD_F00D, 2'b11);
        applyStimulusViolation();

        applyStimulusWrite(0, 32'h0000_0001, 1'b1);
        checkOutput("done_in_start_busy", 32'(busy), 32'd1);
        applyStimulusDone(32'h5555_AAAA, 2'b00);

        applyStimulusWrite(0, 32'h0000_0001, 1'b0);
        applyStimulusReset();
        applyStimulusDone(32'h7777_7777, 2'b11);
        applyStimulusRead(4);
        applyStimulusRead(5);

        for (int n = 0; n < 300; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 4)      applyStimulusWrite($urandom_range(0, 7), $urandom, ($urandom_range(0, 3) == 0));
            else if (op < 8) applyStimulusRead($urandom_range(0, 7));
            else             applyStimulusDone($urandom, 2'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
